comp_stats: RTL and testbench

//   Downstream consumer of the 4-bit magnitude comparator (comp). Accepts operand pairs
//   a/b together with the comparator's L (a>b), E (a==b) and S (a<b) flags over a

---
 rtl/comp_stats.sv | 121 ++++++++++++
 tb/tb_comp_stats.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/comp_stats.sv
// comp_stats: windowed statistics and flag cross-check for the 4-bit comparator.
// Emits one held report per WIN accepted samples over valid/ready handshakes.
module comp_stats #(
    parameter int W   = 4,
    parameter int CW  = 8,
    parameter int WIN = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic          L,
    input  logic          E,
    input  logic          S,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] cnt_l,
    output logic [CW-1:0] cnt_e,
    output logic [CW-1:0] cnt_s,
    output logic [W-1:0]  max_val,
    output logic [W-1:0]  min_val,
    output logic          err_flag
);

    localparam int IW = (WIN > 1) ? $clog2(WIN) : 1;
    localparam logic [CW-1:0] CMAX = {CW{1'b1}};

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_l_q, cnt_l_d;
    logic [CW-1:0] cnt_e_q, cnt_e_d;
    logic [CW-1:0] cnt_s_q, cnt_s_d;
    logic [W-1:0]  max_q, max_d;
    logic [W-1:0]  min_q, min_d;
    logic          err_q, err_d;

    logic accept;
    logic release_rpt;
    logic bad;

    assign accept      = in_valid && (state_q == ACC);
    assign release_rpt = out_ready && (state_q == HOLD);
    assign bad         = (L != (a > b)) | (E != (a == b)) | (S != (a < b));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_l_d = cnt_l_q;
        cnt_e_d = cnt_e_q;
        cnt_s_d = cnt_s_q;
        max_d   = max_q;
        min_d   = min_q;
        err_d   = err_q;
        // clr wins over both a coincident accept and a report consume
        if (clr || release_rpt) begin
            state_d = ACC;
            idx_d   = '0;
            cnt_l_d = '0;
            cnt_e_d = '0;
            cnt_s_d = '0;
            max_d   = '0;
            min_d   = {W{1'b1}};
            err_d   = 1'b0;
        end else if (accept) begin
            if (L && cnt_l_q != CMAX) cnt_l_d = cnt_l_q + CW'(1);
            if (E && cnt_e_q != CMAX) cnt_e_d = cnt_e_q + CW'(1);
            if (S && cnt_s_q != CMAX) cnt_s_d = cnt_s_q + CW'(1);
            if (a > max_d) max_d = a;
            if (b > max_d) max_d = b;
            if (a < min_d) min_d = a;
            if (b < min_d) min_d = b;
            err_d = err_q | bad;
            if (idx_q == IW'(WIN - 1)) begin
                idx_d   = '0;
                state_d = HOLD;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
            idx_q   <= '0;
            cnt_l_q <= '0;
            cnt_e_q <= '0;
            cnt_s_q <= '0;
            max_q   <= '0;
            min_q   <= {W{1'b1}};
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_l_q <= cnt_l_d;
            cnt_e_q <= cnt_e_d;
            cnt_s_q <= cnt_s_d;
            max_q   <= max_d;
            min_q   <= min_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == HOLD);
    assign cnt_l     = cnt_l_q;
    assign cnt_e     = cnt_e_q;
    assign cnt_s     = cnt_s_q;
    assign max_val   = max_q;
    assign min_val   = min_q;
    assign err_flag  = err_q;

endmodule

// File: tb/tb_comp_stats.sv
// tb_comp_stats: random and directed checks of comp_stats against a
// sample-queue reference model that recomputes each report from scratch.
module tb_comp_stats;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       clr, in_valid, out_ready, L, E, S;
    logic [3:0] a, b;
    logic       in_ready, out_valid, err_flag;
    logic [7:0] cnt_l, cnt_e, cnt_s;
    logic [3:0] max_val, min_val;

    comp_stats #(.W(4), .CW(8), .WIN(4)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .L(L), .E(E), .S(S),
        .out_valid(out_valid), .out_ready(out_ready),
        .cnt_l(cnt_l), .cnt_e(cnt_e), .cnt_s(cnt_s),
        .max_val(max_val), .min_val(min_val), .err_flag(err_flag)
    );

    logic       clr2, in_valid2, out_ready2, L2, E2, S2;
    logic [3:0] a2, b2;
    logic       in_ready2, out_valid2, err_flag2;
    logic [1:0] cnt_l2, cnt_e2, cnt_s2;
    logic [3:0] max_val2, min_val2;

    comp_stats #(.W(4), .CW(2), .WIN(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .clr(clr2),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .L(L2), .E(E2), .S(S2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .cnt_l(cnt_l2), .cnt_e(cnt_e2), .cnt_s(cnt_s2),
        .max_val(max_val2), .min_val(min_val2), .err_flag(err_flag2)
    );

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       l;
        logic       e;
        logic       s;
    } smp_t;

    smp_t win_q[$];
    bit   hold = 0;

    function automatic logic [2:0] good(input logic [3:0] x, input logic [3:0] y);
        return {x > y, x == y, x < y};
    endfunction

    task automatic check_all(input string tag);
        int el, ee, es, mx, mn;
        bit er;
        el = 0; ee = 0; es = 0; mx = 0; mn = 15; er = 0;
        foreach (win_q[i]) begin
            el += int'(win_q[i].l);
            ee += int'(win_q[i].e);
            es += int'(win_q[i].s);
            if (int'(win_q[i].a) > mx) mx = int'(win_q[i].a);
            if (int'(win_q[i].b) > mx) mx = int'(win_q[i].b);
            if (int'(win_q[i].a) < mn) mn = int'(win_q[i].a);
            if (int'(win_q[i].b) < mn) mn = int'(win_q[i].b);
            if ({win_q[i].l, win_q[i].e, win_q[i].s} != good(win_q[i].a, win_q[i].b))
                er = 1;
        end
        if (el > 255) el = 255;
        if (ee > 255) ee = 255;
        if (es > 255) es = 255;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(!hold));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(hold));
        chk({tag, ".cnt_l"}, 32'(cnt_l), el);
        chk({tag, ".cnt_e"}, 32'(cnt_e), ee);
        chk({tag, ".cnt_s"}, 32'(cnt_s), es);
        chk({tag, ".max"}, 32'(max_val), mx);
        chk({tag, ".min"}, 32'(min_val), mn);
        chk({tag, ".err"}, 32'(err_flag), 32'(er));
    endtask

    task automatic step(input string tag, input bit v, input logic [3:0] ia,
                        input logic [3:0] ib, input logic [2:0] f,
                        input bit c, input bit ordy);
        smp_t sm;
        in_valid = v; a = ia; b = ib; {L, E, S} = f;
        clr = c; out_ready = ordy;
        @(posedge clk);
        if (c || (hold && ordy)) begin
            win_q.delete();
            hold = 0;
        end else if (v && !hold) begin
            sm.a = ia; sm.b = ib; sm.l = f[2]; sm.e = f[1]; sm.s = f[0];
            win_q.push_back(sm);
            if (win_q.size() == 4) hold = 1;
        end
        #1;
        check_all(tag);
    endtask

    task automatic ok(input string tag, input logic [3:0] x,
                      input logic [3:0] y, input bit ordy);
        step(tag, 1'b1, x, y, good(x, y), 1'b0, ordy);
    endtask

    task automatic idle(input string tag, input bit ordy);
        step(tag, 1'b0, 4'd0, 4'd0, 3'b000, 1'b0, ordy);
    endtask

    initial begin
        logic [3:0] ra, rb;
        logic [2:0] rf;
        clr = 0; in_valid = 0; out_ready = 0; a = 0; b = 0;
        {L, E, S} = 3'b000;
        clr2 = 0; in_valid2 = 0; out_ready2 = 0; a2 = 0; b2 = 0;
        {L2, E2, S2} = 3'b000;

        #12;
        chk("rst.out_valid", 32'(out_valid), 0);
        chk("rst.min", 32'(min_val), 32'hF);
        chk("rst.max", 32'(max_val), 0);
        chk("rst.cnt_l", 32'(cnt_l), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst.in_ready", 32'(in_ready), 1);
        check_all("rst");

        // saturation on the narrow-counter instance
        for (int i = 0; i < 8; i++) begin
            in_valid2 = 1; a2 = 4; b2 = 4; {L2, E2, S2} = 3'b010;
            @(posedge clk);
            #1;
            if (i < 7) chk("sat.ov_early", 32'(out_valid2), 0);
        end
        in_valid2 = 0;
        chk("sat.ov", 32'(out_valid2), 1);
        chk("sat.cnt_e", 32'(cnt_e2), 3);
        chk("sat.cnt_l", 32'(cnt_l2), 0);
        chk("sat.cnt_s", 32'(cnt_s2), 0);
        chk("sat.max", 32'(max_val2), 4);
        chk("sat.min", 32'(min_val2), 4);
        chk("sat.err", 32'(err_flag2), 0);

        // back-to-back window, consumer always ready
        ok("t1", 5, 5, 1);
        ok("t1", 9, 3, 1);
        ok("t1", 2, 7, 1);
        ok("t1", 0, 1, 1);
        chk("t1.ov", 32'(out_valid), 1);
        chk("t1.cnt_l", 32'(cnt_l), 1);
        chk("t1.cnt_e", 32'(cnt_e), 1);
        chk("t1.cnt_s", 32'(cnt_s), 2);
        chk("t1.max", 32'(max_val), 9);
        chk("t1.min", 32'(min_val), 0);
        chk("t1.err", 32'(err_flag), 0);
        idle("t1.rel", 1);
        chk("t1.in_ready", 32'(in_ready), 1);

        // held report with in_valid kept high
        ok("t2", 5, 5, 0);
        ok("t2", 9, 3, 0);
        ok("t2", 2, 7, 0);
        ok("t2", 0, 1, 0);
        for (int i = 0; i < 5; i++) ok("t2.hold", 15, 0, 0);
        chk("t2.in_ready", 32'(in_ready), 0);
        chk("t2.cnt_s", 32'(cnt_s), 2);
        chk("t2.max", 32'(max_val), 9);
        idle("t2.rel", 1);
        chk("t2.rel_min", 32'(min_val), 32'hF);
        chk("t2.rel_cnt_s", 32'(cnt_s), 0);

        // inconsistent flags are counted and flagged
        step("t3", 1, 14, 7, 3'b001, 0, 0);
        step("t3", 1, 3, 3, 3'b110, 0, 0);
        ok("t3", 6, 1, 0);
        ok("t3", 8, 8, 0);
        chk("t3.err", 32'(err_flag), 1);
        chk("t3.cnt_s", 32'(cnt_s), 1);
        chk("t3.cnt_l", 32'(cnt_l), 2);
        chk("t3.cnt_e", 32'(cnt_e), 2);
        idle("t3.rel", 1);

        // clr coincident with a sample drops it and the partial window
        ok("t5", 1, 2, 0);
        ok("t5", 12, 2, 0);
        step("t5.clr", 1, 15, 15, 3'b010, 1, 0);
        chk("t5.cnt_e", 32'(cnt_e), 0);
        ok("t5", 3, 4, 0);
        ok("t5", 4, 3, 0);
        ok("t5", 7, 7, 0);
        chk("t5.ov_early", 32'(out_valid), 0);
        ok("t5", 6, 10, 0);
        chk("t5.ov", 32'(out_valid), 1);
        chk("t5.max", 32'(max_val), 10);
        chk("t5.min", 32'(min_val), 3);
        step("t5.clr_hold", 0, 0, 0, 3'b000, 1, 0);
        chk("t5.ov_drop", 32'(out_valid), 0);

        // async reset while holding a report
        ok("t6", 9, 2, 0);
        ok("t6", 5, 1, 0);
        ok("t6", 2, 2, 0);
        ok("t6", 0, 3, 0);
        chk("t6.ov_pre", 32'(out_valid), 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6.ov", 32'(out_valid), 0);
        chk("t6.min", 32'(min_val), 32'hF);
        chk("t6.max", 32'(max_val), 0);
        chk("t6.cnt_l", 32'(cnt_l), 0);
        chk("t6.cnt_e", 32'(cnt_e), 0);
        chk("t6.cnt_s", 32'(cnt_s), 0);
        win_q.delete();
        hold = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t6.in_ready", 32'(in_ready), 1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rf = ($urandom_range(0, 9) < 7) ? good(ra, rb) : 3'($urandom_range(0, 7));
            step("rnd", $urandom_range(0, 9) < 7, ra, rb, rf,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
